text_writer: RTL and testbench

Upstream feeder for the 80x40 text display. It takes a stream of ASCII bytes from the keyboard decoder and writes them into port A of the text RAM, which the VGA text controller reads through port B. It maintains the cursor position and exports it for the controller's cursor inputs. It also handles line/screen clearing and simple control codes.

---
 rtl/text_writer.sv | 149 ++++++++++++++
 tb/tb_text_writer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_writer.sv
// Keyboard-to-text-RAM feeder for the 80x40 text display: writes characters at the
// cursor, handles Enter/backspace/form feed, and clears rows and the screen.
module text_writer #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 40,
    parameter logic [7:0]  FILL = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  key_data,
    input  logic        key_valid,
    output logic        key_ready,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic [7:0]  cur_x,
    output logic [7:0]  cur_y
);

    localparam int unsigned AW    = 12;
    localparam int unsigned CELLS = COLS * ROWS;

    typedef enum logic [1:0] {CLR_ALL, IDLE, PUT, CLR_ROW} state_t;
    typedef enum logic [1:0] {K_CHAR, K_NL, K_BS} kind_t;

    state_t        state;
    kind_t         kind;
    logic [AW-1:0] cnt;

    logic          accept;
    logic          printable;
    logic          at_home;
    logic [7:0]    next_y;
    logic [7:0]    bs_x;
    logic [7:0]    bs_y;
    logic [AW-1:0] cell_addr;
    logic [AW-1:0] row_base;
    logic [AW-1:0] next_row_base;
    logic [AW-1:0] bs_addr;

    assign accept        = key_valid & key_ready;
    assign printable     = (key_data >= 8'h20) && (key_data <= 8'h7E);
    assign at_home       = (cur_x == 8'd0) && (cur_y == 8'd0);
    assign next_y        = (cur_y == 8'(ROWS - 1)) ? 8'd0 : cur_y + 8'd1;
    assign bs_x          = (cur_x == 8'd0) ? 8'(COLS - 1) : cur_x - 8'd1;
    assign bs_y          = (cur_x == 8'd0) ? cur_y - 8'd1 : cur_y;
    assign row_base      = AW'(cur_y) * AW'(COLS);
    assign next_row_base = AW'(next_y) * AW'(COLS);
    assign cell_addr     = row_base + AW'(cur_x);
    assign bs_addr       = AW'(bs_y) * AW'(COLS) + AW'(bs_x);

    // cnt counts clear writes already issued in CLR_ALL / CLR_ROW
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLR_ALL;
            kind      <= K_CHAR;
            cnt       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= FILL;
            cur_x     <= 8'd0;
            cur_y     <= 8'd0;
            key_ready <= 1'b0;
        end else begin
            case (state)
                CLR_ALL: begin
                    if (cnt < AW'(CELLS)) begin
                        ram_we   <= 1'b1;
                        ram_addr <= cnt;
                        ram_din  <= FILL;
                        cnt      <= cnt + AW'(1);
                    end else begin
                        ram_we    <= 1'b0;
                        key_ready <= 1'b1;
                        cur_x     <= 8'd0;
                        cur_y     <= 8'd0;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    ram_we <= 1'b0;
                    if (accept) begin
                        if (printable) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= cell_addr;
                            ram_din   <= key_data;
                            key_ready <= 1'b0;
                            kind      <= K_CHAR;
                            state     <= PUT;
                        end else if (key_data == 8'h0C) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= '0;
                            ram_din   <= FILL;
                            cnt       <= AW'(1);
                            cur_x     <= 8'd0;
                            cur_y     <= 8'd0;
                            key_ready <= 1'b0;
                            state     <= CLR_ALL;
                        end else if (key_data == 8'h0D) begin
                            key_ready <= 1'b0;
                            kind      <= K_NL;
                            state     <= PUT;
                        end else if (key_data == 8'h08 && !at_home) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= bs_addr;
                            ram_din   <= FILL;
                            cur_x     <= bs_x;
                            cur_y     <= bs_y;
                            key_ready <= 1'b0;
                            kind      <= K_BS;
                            state     <= PUT;
                        end
                    end
                end
                PUT: begin
                    if (kind == K_BS || (kind == K_CHAR && cur_x != 8'(COLS - 1))) begin
                        ram_we    <= 1'b0;
                        key_ready <= 1'b1;
                        if (kind == K_CHAR) cur_x <= cur_x + 8'd1;
                        state     <= IDLE;
                    end else begin
                        // row advance: first clear write overlaps the cursor update
                        cur_x    <= 8'd0;
                        cur_y    <= next_y;
                        ram_we   <= 1'b1;
                        ram_addr <= next_row_base;
                        ram_din  <= FILL;
                        cnt      <= AW'(1);
                        state    <= CLR_ROW;
                    end
                end
                CLR_ROW: begin
                    if (cnt < AW'(COLS)) begin
                        ram_we   <= 1'b1;
                        ram_addr <= row_base + cnt;
                        ram_din  <= FILL;
                        cnt      <= cnt + AW'(1);
                    end else begin
                        ram_we    <= 1'b0;
                        key_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: clears, printable writes, wrap, Enter, backspace, reset abort.
module tb_text_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  key_data = 8'h00;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  cur_x;
    logic [7:0]  cur_y;

    int errors = 0;
    int checks = 0;
    int timeouts = 0;

    text_writer dut (
        .clk(clk), .reset(reset),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 clk = ~clk;

    // Present a byte and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        key_data  = d;
        key_valid = 1'b1;
        while (key_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeouts++;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (key_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeouts++;
    endtask

    // Counts cycles deviating from a FILL write at base+i over n consecutive cycles.
    task automatic sweep(input int base, input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ram_we !== 1'b1 || ram_addr !== 12'(base + i) || ram_din !== 8'h20) bad++;
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: we=%0b ready=%0b want 0 0", ram_we, key_ready);
        end
        checks++;
        if (ram_addr !== 12'd0 || ram_din !== 8'h20 || cur_x !== 8'd0 || cur_y !== 8'd0) begin
            errors++;
            $display("FAIL reset_vals: addr=%0d din=%h x=%0d y=%0d want 0 20 0 0", ram_addr, ram_din, cur_x, cur_y);
        end
        reset = 1'b0;
        sweep(0, 3200, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_clear: bad_cycles=%0d want 0", bad);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || ram_we !== 1'b0 || cur_x !== 8'd0 || cur_y !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle: ready=%0b we=%0b x=%0d y=%0d want 1 0 0 0", key_ready, ram_we, cur_x, cur_y);
        end
    endtask

    task automatic test_ab();
        key_data  = 8'h41;
        key_valid = 1'b1;
        @(posedge clk);
        #1 key_data = 8'h42;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 12'd0 || ram_din !== 8'h41 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL ab_first: we=%0b addr=%0d din=%h ready=%0b want 1 0 41 0", ram_we, ram_addr, ram_din, key_ready);
        end
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || key_ready !== 1'b1 || cur_x !== 8'd1) begin
            errors++;
            $display("FAIL ab_gap: we=%0b ready=%0b x=%0d want 0 1 1", ram_we, key_ready, cur_x);
        end
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 12'd1 || ram_din !== 8'h42) begin
            errors++;
            $display("FAIL ab_second: we=%0b addr=%0d din=%h want 1 1 42", ram_we, ram_addr, ram_din);
        end
        @(negedge clk);
        checks++;
        if (cur_x !== 8'd2 || cur_y !== 8'd0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL ab_cursor: x=%0d y=%0d ready=%0b want 2 0 1", cur_x, cur_y, key_ready);
        end
    endtask

    task automatic test_form_feed();
        int bad;
        send_byte(8'h0C);
        sweep(0, 3200, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ff_clear: bad_cycles=%0d want 0", bad);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || ram_we !== 1'b0 || cur_x !== 8'd0 || cur_y !== 8'd0) begin
            errors++;
            $display("FAIL ff_home: ready=%0b we=%0b x=%0d y=%0d want 1 0 0 0", key_ready, ram_we, cur_x, cur_y);
        end
    endtask

    task automatic test_line_wrap();
        int bad = 0;
        int cbad;
        for (int i = 0; i < 80; i++) begin
            send_byte(8'(8'h21 + i));
            @(negedge clk);
            if (ram_we !== 1'b1 || ram_addr !== 12'(i) || ram_din !== 8'(8'h21 + i)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wrap_chars: bad_writes=%0d want 0", bad);
        end
        sweep(80, 80, cbad);
        checks++;
        if (cbad !== 0) begin
            errors++;
            $display("FAIL wrap_rowclear: bad_cycles=%0d want 0", cbad);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || ram_we !== 1'b0 || cur_x !== 8'd0 || cur_y !== 8'd1) begin
            errors++;
            $display("FAIL wrap_cursor: ready=%0b we=%0b x=%0d y=%0d want 1 0 0 1", key_ready, ram_we, cur_x, cur_y);
        end
    endtask

    task automatic test_enter_wrap();
        int bad;
        for (int i = 0; i < 38; i++) begin
            send_byte(8'h0D);
            wait_idle();
        end
        checks++;
        if (cur_x !== 8'd0 || cur_y !== 8'd39) begin
            errors++;
            $display("FAIL enter_reach: x=%0d y=%0d want 0 39", cur_x, cur_y);
        end
        send_byte(8'h0D);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL enter_nowrite: we=%0b ready=%0b want 0 0", ram_we, key_ready);
        end
        sweep(0, 80, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL enter_rowclear: bad_cycles=%0d want 0", bad);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || cur_x !== 8'd0 || cur_y !== 8'd0) begin
            errors++;
            $display("FAIL enter_cursor: ready=%0b x=%0d y=%0d want 1 0 0", key_ready, cur_x, cur_y);
        end
    endtask

    task automatic test_backspace();
        send_byte(8'h08);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || key_ready !== 1'b1 || cur_x !== 8'd0 || cur_y !== 8'd0) begin
            errors++;
            $display("FAIL bs_home: we=%0b ready=%0b x=%0d y=%0d want 0 1 0 0", ram_we, key_ready, cur_x, cur_y);
        end
        send_byte(8'h01);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || key_ready !== 1'b1 || cur_x !== 8'd0 || cur_y !== 8'd0) begin
            errors++;
            $display("FAIL discard: we=%0b ready=%0b x=%0d y=%0d want 0 1 0 0", ram_we, key_ready, cur_x, cur_y);
        end
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h0D);
            wait_idle();
        end
        checks++;
        if (cur_x !== 8'd0 || cur_y !== 8'd5) begin
            errors++;
            $display("FAIL bs_setup: x=%0d y=%0d want 0 5", cur_x, cur_y);
        end
        send_byte(8'h08);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 12'd399 || ram_din !== 8'h20) begin
            errors++;
            $display("FAIL bs_rowup_write: we=%0b addr=%0d din=%h want 1 399 20", ram_we, ram_addr, ram_din);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || ram_we !== 1'b0 || cur_x !== 8'd79 || cur_y !== 8'd4) begin
            errors++;
            $display("FAIL bs_rowup_cursor: ready=%0b we=%0b x=%0d y=%0d want 1 0 79 4", key_ready, ram_we, cur_x, cur_y);
        end
        send_byte(8'h08);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 12'd398 || ram_din !== 8'h20) begin
            errors++;
            $display("FAIL bs_left_write: we=%0b addr=%0d din=%h want 1 398 20", ram_we, ram_addr, ram_din);
        end
        @(negedge clk);
        checks++;
        if (cur_x !== 8'd78 || cur_y !== 8'd4) begin
            errors++;
            $display("FAIL bs_left_cursor: x=%0d y=%0d want 78 4", cur_x, cur_y);
        end
    endtask

    task automatic test_reset_mid_clear();
        int bad;
        send_byte(8'h0C);
        sweep(0, 1000, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_prefix: bad_cycles=%0d want 0", bad);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b0 || key_ready !== 1'b0 || ram_addr !== 12'd0) begin
            errors++;
            $display("FAIL abort_async: we=%0b ready=%0b addr=%0d want 0 0 0", ram_we, key_ready, ram_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        sweep(0, 3200, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_restart: bad_cycles=%0d want 0", bad);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || cur_x !== 8'd0 || cur_y !== 8'd0) begin
            errors++;
            $display("FAIL abort_idle: ready=%0b x=%0d y=%0d want 1 0 0", key_ready, cur_x, cur_y);
        end
    endtask

    task automatic test_no_stall();
        checks++;
        if (timeouts !== 0) begin
            errors++;
            $display("FAIL handshake_timeouts: got %0d want 0", timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_ab();
        test_form_feed();
        test_line_wrap();
        test_enter_wrap();
        test_backspace();
        test_reset_mid_clear();
        test_no_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
